// File: rtl/mod_arith_pkg.sv
// Shared types and helpers for the sequential modular add/sub datapath.
package mod_arith_pkg;

    typedef enum logic [1:0] {IDLE, PASS1, PASS2} mas_state_e;
    typedef enum logic {OP_ADD, OP_SUB} mas_op_e;

    function automatic int nchunks(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/mod_chunk_add.sv
// One CHUNK-bit slice of the ripple: {cout, sum} = a + b + cin.
// Purely combinational, no backpressure.
module mod_chunk_add #(
    parameter int CHUNK = 64
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/mod_addsub_seq.sv
// Modular add/sub, one CHUNK slice per cycle over two passes; latency 2*WIDTH/CHUNK, one op in flight,
// i_start ignored while busy. Optional o_range_err under MODADDSUB_RANGE_CHK_EN.
module mod_addsub_seq
    import mod_arith_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int CHUNK = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_p,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_result,
`ifdef MODADDSUB_RANGE_CHK_EN
    output logic             o_done,
    output logic             o_range_err
`else
    output logic             o_done
`endif
);

    localparam int NCH = nchunks(WIDTH, CHUNK);
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);

    if (WIDTH % CHUNK != 0) begin : g_chk
        $error("mod_addsub_seq: WIDTH must be a multiple of CHUNK");
    end

    mas_state_e       state_q, state_d;
    mas_op_e          op_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] a_q, b_q, p_q, s_q, t_q;
    logic             carry_q, c1_q;
    logic             accept, last_chunk;
    logic [CHUNK-1:0] x, y, sum;
    logic             cin, cout;
    logic [WIDTH-1:0] s_in, s_rot, t_in, sel;
    logic [WIDTH+CHUNK-1:0] s_cat, r_cat, t_cat;

    assign o_ready    = (state_q == IDLE);
    assign accept     = i_start && o_ready;
    assign last_chunk = (idx_q == LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = PASS1;
            PASS1:   if (last_chunk) state_d = PASS2;
            PASS2:   if (last_chunk) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pass 1 adds A and (+/-)B; pass 2 applies -P (add) or +P (sub) to the raw sum.
    always_comb begin
        x   = '0;
        y   = '0;
        cin = 1'b0;
        if (state_q == PASS1) begin
            x   = a_q[CHUNK-1:0];
            y   = (op_q == OP_SUB) ? ~b_q[CHUNK-1:0] : b_q[CHUNK-1:0];
            cin = (idx_q == '0) ? (op_q == OP_SUB) : carry_q;
        end else if (state_q == PASS2) begin
            x   = s_q[CHUNK-1:0];
            y   = (op_q == OP_ADD) ? ~p_q[CHUNK-1:0] : p_q[CHUNK-1:0];
            cin = (idx_q == '0) ? (op_q == OP_ADD) : carry_q;
        end
    end

    mod_chunk_add #(.CHUNK(CHUNK)) u_chunk (
        .a    (x),
        .b    (y),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    // Results enter from the top; s is rotated during pass 2 so it is whole again at the end.
    assign s_cat = {sum, s_q};
    assign r_cat = {s_q[CHUNK-1:0], s_q};
    assign t_cat = {sum, t_q};
    assign s_in  = s_cat[WIDTH+CHUNK-1:CHUNK];
    assign s_rot = r_cat[WIDTH+CHUNK-1:CHUNK];
    assign t_in  = t_cat[WIDTH+CHUNK-1:CHUNK];

    always_comb begin
        sel = s_rot;
        if (op_q == OP_ADD) begin
            if (c1_q || cout) sel = t_in;
        end else begin
            if (!c1_q) sel = t_in;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
        end else begin
            state_q  <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_q     <= OP_ADD;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            s_q      <= '0;
            t_q      <= '0;
            carry_q  <= 1'b0;
            c1_q     <= 1'b0;
            o_result <= '0;
            o_done   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (accept) begin
                op_q    <= mas_op_e'(i_op);
                a_q     <= i_a;
                b_q     <= i_b;
                p_q     <= i_p;
                idx_q   <= '0;
                carry_q <= 1'b0;
            end else if (state_q == PASS1) begin
                a_q     <= a_q >> CHUNK;
                b_q     <= b_q >> CHUNK;
                s_q     <= s_in;
                carry_q <= cout;
                idx_q   <= last_chunk ? '0 : idx_q + IW'(1);
                if (last_chunk) c1_q <= cout;
            end else if (state_q == PASS2) begin
                p_q     <= p_q >> CHUNK;
                s_q     <= s_rot;
                t_q     <= t_in;
                carry_q <= cout;
                idx_q   <= last_chunk ? '0 : idx_q + IW'(1);
                if (last_chunk) begin
                    o_result <= sel;
                    o_done   <= 1'b1;
                end
            end
        end
    end

`ifdef MODADDSUB_RANGE_CHK_EN
    logic range_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            range_q     <= 1'b0;
            o_range_err <= 1'b0;
        end else begin
            if (accept) range_q <= (i_a >= i_p) | (i_b >= i_p) | (i_p == '0);
            if (state_q == PASS2 && last_chunk) o_range_err <= range_q;
        end
    end
`endif

endmodule

// File: tb/tb_mod_addsub_seq.sv
// Randomized + directed bench for mod_addsub_seq against a queue-based arithmetic reference model.
module tb_mod_addsub_seq;

    localparam logic [255:0] SP = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] SP_M2 = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2D;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, op_i = 1'b0;
    logic [15:0] a_i = '0, b_i = '0, p_i = 16'hFFF1;
    logic        ready, done;
    logic [15:0] result;

    logic         w_start = 1'b0, w_op = 1'b0;
    logic [255:0] w_a = '0, w_b = '0, w_p = '0;
    logic         w_ready, w_done;
    logic [255:0] w_result;

`ifdef MODADDSUB_RANGE_CHK_EN
    logic range_err, w_range_err;
`endif

    always #5 clk = ~clk;

    mod_addsub_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op_i),
        .i_a(a_i), .i_b(b_i), .i_p(p_i),
        .o_ready(ready), .o_result(result),
`ifdef MODADDSUB_RANGE_CHK_EN
        .o_done(done), .o_range_err(range_err)
`else
        .o_done(done)
`endif
    );

    mod_addsub_seq #(.WIDTH(256), .CHUNK(64)) dut256 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(w_start), .i_op(w_op),
        .i_a(w_a), .i_b(w_b), .i_p(w_p),
        .o_ready(w_ready), .o_result(w_result),
`ifdef MODADDSUB_RANGE_CHK_EN
        .o_done(w_done), .o_range_err(w_range_err)
`else
        .o_done(w_done)
`endif
    );

    typedef struct {
        int          idx;
        logic        known;
        logic [15:0] res;
        logic        rerr;
    } sb_t;

    sb_t         sb[$];
    int          neg_cnt = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [15:0] last_res = '0;
    logic        res_known = 1'b1;
    logic        last_rerr = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [15:0] model_res(input logic op, input int a, input int b, input int p);
        if (p == 0) return 16'h0;
        if (!op) return 16'((a + b) % p);
        return 16'((a - b + p) % p);
    endfunction

    // Every negedge: o_done only on the predicted cycle, o_ready idle-only, o_result held.
    always @(negedge clk) begin
        logic exp_done;
        neg_cnt++;
        exp_done = 1'b0;
        if (sb.size() > 0 && sb[0].idx == neg_cnt) begin
            exp_done  = 1'b1;
            res_known = sb[0].known;
            last_res  = sb[0].res;
            last_rerr = sb[0].rerr;
            void'(sb.pop_front());
        end
        chk("o_done", done, exp_done);
        chk("o_ready", ready, sb.size() == 0);
        if (res_known) chk("o_result", result, last_res);
`ifdef MODADDSUB_RANGE_CHK_EN
        chk("o_range_err", range_err, last_rerr);
`endif
    end

    task automatic cycle_in(input logic st, input logic op, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] p, input logic lit_en, input logic [15:0] lit);
        sb_t e;
        @(negedge clk); #1;
        start = st; op_i = op; a_i = a; b_i = b; p_i = p;
        if (st && rst_n && sb.size() == 0) begin
            e.idx   = neg_cnt + 9;
            e.known = lit_en || ((a < p) && (b < p) && (p != 0));
            e.res   = lit_en ? lit : model_res(op, int'(a), int'(b), int'(p));
            e.rerr  = (a >= p) || (b >= p) || (p == 0);
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle_in(1'b0, 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 16'h0);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst_n = 1'b0; start = 1'b0;
        sb.delete();
        last_res = '0; res_known = 1'b1; last_rerr = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct { logic op; logic [15:0] a; logic [15:0] b; logic [15:0] exp; } dir_t;
    dir_t dirs[5] = '{
        '{1'b0, 16'h0001, 16'h0002, 16'h0003},
        '{1'b0, 16'hFFF0, 16'h0005, 16'h0004},
        '{1'b0, 16'hFFF0, 16'h0001, 16'h0000},
        '{1'b1, 16'h0003, 16'h0005, 16'hFFEF},
        '{1'b1, 16'h0007, 16'h0007, 16'h0000}
    };

    initial begin
        int k;
        logic [15:0] rp, ra, rb;

        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        foreach (dirs[i])
            chk("model pin", model_res(dirs[i].op, int'(dirs[i].a), int'(dirs[i].b), 32'hFFF1), dirs[i].exp);

        foreach (dirs[i]) begin
            cycle_in(1'b1, dirs[i].op, dirs[i].a, dirs[i].b, 16'hFFF1, 1'b1, dirs[i].exp);
            idle(10);
        end

        // starts at busy cycles 2 and 5 must be dropped
        cycle_in(1'b1, 1'b0, 16'h0001, 16'h0002, 16'hFFF1, 1'b1, 16'h0003);
        idle(1);
        cycle_in(1'b1, 1'b1, 16'h0009, 16'h0008, 16'hFFF1, 1'b0, 16'h0);
        idle(2);
        cycle_in(1'b1, 1'b1, 16'h0009, 16'h0008, 16'hFFF1, 1'b0, 16'h0);
        idle(8);

        // back-to-back: second start lands in the o_done cycle
        cycle_in(1'b1, 1'b0, 16'h0001, 16'h0002, 16'hFFF1, 1'b1, 16'h0003);
        idle(8);
        cycle_in(1'b1, 1'b0, 16'h0005, 16'h0006, 16'hFFF1, 1'b1, 16'h000B);
        idle(10);

        // reset during PASS2 cycle 1
        cycle_in(1'b1, 1'b0, 16'h1234, 16'h0011, 16'hFFF1, 1'b1, 16'h1245);
        idle(5);
        do_reset();
        cycle_in(1'b1, 1'b0, 16'h0001, 16'h0002, 16'hFFF1, 1'b1, 16'h0003);
        idle(10);

        for (int i = 0; i < 400; i++) begin
            rp = 16'($urandom_range(1, 65535));
            ra = 16'($urandom_range(0, int'(rp) - 1));
            rb = 16'($urandom_range(0, int'(rp) - 1));
            if ($urandom_range(0, 15) == 0) ra = 16'($urandom);
            cycle_in($urandom_range(0, 2) == 0, 1'($urandom), ra, rb, rp, 1'b0, 16'h0);
        end
        idle(10);

`ifdef MODADDSUB_RANGE_CHK_EN
        cycle_in(1'b1, 1'b0, 16'hFFF1, 16'h0001, 16'hFFF1, 1'b0, 16'h0);
        idle(10);
        cycle_in(1'b1, 1'b0, 16'h0001, 16'h0001, 16'hFFF1, 1'b1, 16'h0002);
        idle(10);
`endif

        @(negedge clk); #1;
        w_start = 1'b1; w_op = 1'b0; w_a = SP - 256'd1; w_b = SP - 256'd1; w_p = SP;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                #1 w_start = 1'b0; w_a = '0; w_b = '0;
            end
            if (w_done) break;
        end
        chk("w256 latency", 256'(k - 1), 256'd8);
        chk("w256 result", w_result, SP_M2);

        for (k = 0; k < 30 && sb.size() > 0; k++) @(negedge clk);
        chk("drain", 256'(sb.size()), 256'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
